// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption, one round per clock.
//
// The round key is expanded on the fly from the previous round key, so no key
// schedule storage is needed. A start/busy/done handshake wraps the datapath.
// Byte 0 of any block or key sits in bits [127:120].
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       request to encrypt; only sampled while idle
//   plaintext   block captured on an accepted start
//   key         cipher key captured on an accepted start
//   busy        high while rounds are in progress
//   done        one-cycle pulse when ciphertext is valid
//   ciphertext  result register; holds until the next done
//   last_key    round-10 key, loaded together with ciphertext
//               (only when AES_ENC_LASTKEY_EN is defined)
//
// Optional feature macro: AES_ENC_LASTKEY_EN

module aes_encrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
`ifdef AES_ENC_LASTKEY_EN
  ,
  output logic [127:0] last_key
`endif
);

  typedef enum logic [0:0] {StIdle, StRun} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q;
  logic [127:0] rkey_q;
  logic [3:0]   rnd_q;
  logic         done_q, done_d;
  logic [127:0] ct_q;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers and S-box
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule: next round key from the current one
  // ---------------------------------------------------------------------------
  logic [7:0]   rcon;
  logic [31:0]  rot_w, key_tmp;
  logic [31:0]  nk0, nk1, nk2, nk3;
  logic [127:0] rkey_next;

  always_comb begin
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    rot_w   = {rkey_q[23:0], rkey_q[31:24]};
    key_tmp = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])} ^
              {rcon, 24'h000000};
    nk0       = rkey_q[127:96] ^ key_tmp;
    nk1       = rkey_q[95:64] ^ nk0;
    nk2       = rkey_q[63:32] ^ nk1;
    nk3       = rkey_q[31:0] ^ nk2;
    rkey_next = {nk0, nk1, nk2, nk3};
  end

  // ---------------------------------------------------------------------------
  // Round datapath: SubBytes -> ShiftRows -> MixColumns
  // Byte n of the block is row n%4, column n/4.
  // ---------------------------------------------------------------------------
  logic [127:0] sb_blk, sr_blk, mc_blk;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb_blk[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates left by r columns.
      assign sr_blk[127-8*(r+4*c) -: 8] = sb_blk[127-8*(r+4*((c+r)%4)) -: 8];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_blk[127-32*c -: 8];
    assign a1 = sr_blk[119-32*c -: 8];
    assign a2 = sr_blk[111-32*c -: 8];
    assign a3 = sr_blk[103-32*c -: 8];

    assign mc_blk[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_blk[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_blk[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_blk[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic rnd_valid, rnd_last;
  assign rnd_valid = (rnd_q != 4'd0) && (rnd_q <= 4'd10);
  assign rnd_last  = (rnd_q == 4'd10);

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= StIdle;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle: if (start) fsm_d = StRun;
      // An out-of-range round count abandons the block silently.
      StRun:  if (!rnd_valid || rnd_last) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (fsm_q == StRun);
    done_d = (fsm_q == StRun) && rnd_last;
  end

  assign done       = done_q;
  assign ciphertext = ct_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
      ct_q    <= '0;
    end else begin
      done_q <= done_d;
      if (fsm_q == StIdle) begin
        if (start) begin
          state_q <= plaintext ^ key;
          rkey_q  <= key;
          rnd_q   <= 4'd1;
        end
      end else if (rnd_valid) begin
        rkey_q <= rkey_next;
        if (rnd_last) begin
          ct_q  <= sr_blk ^ rkey_next;
          rnd_q <= 4'd0;
        end else begin
          state_q <= mc_blk ^ rkey_next;
          rnd_q   <= rnd_q + 4'd1;
        end
      end else begin
        rnd_q <= 4'd0;
      end
    end
  end

`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] last_key_q;

  always_ff @(posedge clk) begin
    if (rst)             last_key_q <= '0;
    else if (done_d)     last_key_q <= rkey_next;
  end

  assign last_key = last_key_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, back-to-back
// operation, ignored start while busy, reset mid-run, and random blocks
// compared against a byte-array AES-128 reference model.

module tb_aes_encrypt_iter;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;
`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] last_key;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] BKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BPt  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BCt  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BLk  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZCt  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_iter u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .busy       (busy),
    .done       (done),
`ifdef AES_ENC_LASTKEY_EN
    .last_key   (last_key),
`endif
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] m_xtime(input logic [7:0] b);
    return (b << 1) ^ ((b & 8'h80) != 0 ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) p ^= x;
      x = m_xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Table built by brute-force inverse search plus the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_t[x] = s;
    end
  endtask

  task automatic model_encrypt(input logic [127:0] pt, input logic [127:0] k,
                               output logic [127:0] ct, output logic [127:0] lk);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = m_xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (rd < 10)
            s[r][c] = m_gmul(8'h02, t[r][c]) ^ m_gmul(8'h03, t[(r+1)%4][c]) ^
                      t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] ^= w[4*rd+c][31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ct[127-8*(r+4*c) -: 8] = s[r][c];
    lk = {w[40], w[41], w[42], w[43]};
  endtask

  // ---------------------------------------------------------------------------
  // Encrypt one block; optionally pulse start at cycles 3 and 7 while busy.
  // ---------------------------------------------------------------------------
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp_ct, input bit noise);
    int lat;
    int ndone;
`ifdef AES_ENC_LASTKEY_EN
    logic [127:0] m_ct;
    logic [127:0] m_lk;
    model_encrypt(pt, k, m_ct, m_lk);
`endif
    plaintext = pt;
    key       = k;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    plaintext = ~pt;
    key       = ~k;
    check_val({tag, "_busy"}, 128'(busy), 128'd1);
    lat   = 0;
    ndone = 0;
    for (int n = 1; n <= 14; n++) begin
      start = noise && (n == 3 || n == 7);
      if (start) plaintext = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = n;
          check_val({tag, "_ct"}, ciphertext, exp_ct);
          check_val({tag, "_busy_at_done"}, 128'(busy), 128'd0);
`ifdef AES_ENC_LASTKEY_EN
          check_val({tag, "_lastkey"}, last_key, m_lk);
`endif
        end
      end
    end
    check_val({tag, "_latency"}, 128'(lat), 128'd10);
    check_val({tag, "_ndone"}, 128'(ndone), 128'd1);
    check_val({tag, "_ct_hold"}, ciphertext, exp_ct);
  endtask

  initial begin
    logic [127:0] r_pt, r_key, r_ct, r_lk;
    int d1, d2, bad, nd;

    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    build_sbox();

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_done", 128'(done), 128'd0);
    check_val("rst_ct", ciphertext, 128'd0);
`ifdef AES_ENC_LASTKEY_EN
    check_val("rst_lastkey", last_key, 128'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_block("appB", BPt, BKey, BCt, 1'b0);
`ifdef AES_ENC_LASTKEY_EN
    check_val("appB_lastkey_const", last_key, BLk);
`endif
    run_block("appC1", CPt, CKey, CCt, 1'b0);
    run_block("zero_noise", 128'd0, 128'd0, ZCt, 1'b1);

    // Back-to-back with start held high; switch to App C.1 in the done cycle.
    plaintext = BPt;
    key       = BKey;
    start     = 1'b1;
    @(posedge clk); #1;
    d1  = 0;
    d2  = 0;
    bad = 0;
    for (int n = 1; n <= 30 && d2 == 0; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 == 0) begin
          d1 = n;
          check_val("b2b_ct1", ciphertext, BCt);
          plaintext = CPt;
          key       = CKey;
        end else begin
          d2 = n;
          check_val("b2b_ct2", ciphertext, CCt);
          start = 1'b0;
        end
      end else if (d1 != 0 && ciphertext !== BCt) begin
        bad++;
      end
    end
    start = 1'b0;
    check_val("b2b_first_latency", 128'(d1), 128'd10);
    check_val("b2b_spacing", 128'(d2 - d1), 128'd11);
    check_val("b2b_ct_stable", 128'(bad), 128'd0);
    repeat (12) @(posedge clk);
    #1;

    // Reset in the middle of a run, just before round 5.
    plaintext = CPt;
    key       = CKey;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_busy", 128'(busy), 128'd0);
    check_val("midrst_done", 128'(done), 128'd0);
    check_val("midrst_ct", ciphertext, 128'd0);
    nd = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check_val("midrst_no_done", 128'(nd), 128'd0);
    check_val("midrst_idle", 128'(busy), 128'd0);
    run_block("after_rst_appB", BPt, BKey, BCt, 1'b0);

    // Random blocks against the reference model.
    for (int i = 0; i < 6; i++) begin
      r_pt  = {$urandom, $urandom, $urandom, $urandom};
      r_key = {$urandom, $urandom, $urandom, $urandom};
      model_encrypt(r_pt, r_key, r_ct, r_lk);
      run_block($sformatf("rand%0d", i), r_pt, r_key, r_ct, i[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES-128 encryption core: one round per clock, with on-the-fly key expansion. It is the forward-direction counterpart of the team's decrypt round datapath, and it produces the ciphertext that the decrypt path consumes. A start/busy/done handshake wraps it so that a single controller can sequence encryption and decryption. Byte ordering follows FIPS-197: byte 0 of a block or key is bits [127:120].

## Interface
- No parameters. The key size is fixed at 128 bits and Nr is fixed at 10.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request to encrypt; sampled only in IDLE
- plaintext  in  128  block captured on an accepted start
- key  in  128  cipher key captured on an accepted start
- busy  out  1  high while rounds are in progress
- done  out  1  one-cycle pulse when ciphertext is valid
- ciphertext  out  128  result register; holds until the next done
- last_key  out  128  round-10 key (present only with AES_ENC_LASTKEY_EN)

## Operation
- FSM states: IDLE and RUN.
- IDLE, start=1: the block is accepted.
  - state_reg <= plaintext ^ key (initial AddRoundKey).
  - rkey_reg <= key; rnd <= 1; go to RUN.
- IDLE, start=0: hold all registers.
- RUN, rnd 1..9, each cycle:
  - Next round key: rk' = KeyExpand(rkey_reg, Rcon[rnd]). This is RotWord, SubWord and Rcon on w3, then the w0..w3 XOR chain.
  - state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk'.
  - rkey_reg <= rk'; rnd <= rnd+1.
- RUN, rnd 10:
  - ciphertext <= ShiftRows(SubBytes(state_reg)) ^ rk'. MixColumns is skipped.
  - rkey_reg <= rk'; done <= 1; go to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
- rnd is a 4-bit counter. Values 0 and 11..15 are unreachable; if one occurs, the FSM returns to IDLE without pulsing done.
- start while busy=1 is ignored; it is neither queued nor does it abort the run.
- plaintext and key may change freely after the accept cycle.
- The datapath is 16 S-box instances for the state plus 4 for the key schedule, all combinational between the registers.

## Timing
- Reset values: busy=0, done=0, ciphertext=0, last_key=0, FSM=IDLE, rnd=0.
- rst has priority over all activity, including a run in progress. After a reset mid-run:
  - busy=0 and done=0 on the next cycle.
  - No done pulse is emitted for the aborted block.
- Edge E0 samples start=1: busy=1 from E0 onward.
- Edges E1..E10 perform rounds 1..10.
- After E10: done=1 for exactly one cycle, busy=0, and ciphertext is valid.
- Latency is 10 cycles from the accepting edge to done. Throughput is one block per 11 cycles.
- start may be high in the same cycle as done=1. The FSM is in IDLE then, so the next block is accepted at that edge, giving back-to-back throughput.
- ciphertext changes only at a done-producing edge or at reset.

## Configuration
- Macro: AES_ENC_LASTKEY_EN.
- Defined:
  - Port last_key exists and is loaded with the round-10 key at the same edge as ciphertext.
  - last_key holds until the next done or reset.
  - This lets the decrypt path start its inverse key schedule without re-expanding the key.
- Undefined:
  - Port last_key is absent.
  - rkey_reg is internal only; no extra register is built.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32. done is a single pulse 10 cycles after the accept edge. With the macro: last_key d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Also in this run: pulse start again at cycles 3 and 7 while busy; the result is unchanged and exactly one done is seen.
- Back-to-back: hold start=1 continuously, with the vector switched to App. C.1 in the done cycle. Required: both results correct, done pulses exactly 11 cycles apart, and ciphertext stable between pulses.
- Reset mid-run: assert rst at round 5. Required: busy=0, done=0 and ciphertext=0 after the reset cycle, with no stray done. Then restart with the App. B vector and get the correct ciphertext.
